// File: rtl/mips_mc_controller.sv
// Multicycle main-control FSM for TinyMIPS: beat-wise instruction fetch, decode and datapath strobes.
// Optional bne support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_mc_controller #(
    parameter int WIDTH = 8,
    localparam int NBEAT = 32 / WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             memread,
    output logic             memwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic             memtoreg,
    output logic             iord,
    output logic             regwrite,
    output logic             regdst,
    output logic [1:0]       pcsource,
    output logic [NBEAT-1:0] irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic             branch_ne,
    output logic             illegal_op
);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_width_check
        $error("mips_mc_controller: WIDTH must be 8, 16 or 32");
    end

    localparam int BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR,
        S_REX, S_RWB, S_BEQ, S_JMP, S_AEX, S_AWB, S_BNE
    } state_t;

    state_t        state, state_next;
    logic [BW-1:0] beat, beat_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    always_comb begin
        state_next = state;
        beat_next  = beat;
        memread    = 1'b0;
        memwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        memtoreg   = 1'b0;
        iord       = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        pcsource   = 2'b00;
        irwrite    = '0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
                beat_next  = '0;
            end
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                // A beat only completes (IR load + PC bump) when memory answers.
                if (mem_ready) begin
                    irwrite[beat] = 1'b1;
                    pcwrite       = 1'b1;
                    if (beat == BW'(NBEAT - 1)) begin
                        state_next = S_DECODE;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat + BW'(1);
                    end
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LB, OP_SB: state_next = S_MEMADR;
                    OP_R:         state_next = S_REX;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_J:         state_next = S_JMP;
                    OP_ADDI:      state_next = S_AEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_next = S_BNE;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_SB) ? S_SBWR : S_LBRD;
            end
            S_LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_next = S_LBWR;
            end
            S_LBWR: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                state_next = S_FETCH;
            end
            S_SBWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_REX: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                state_next = S_RWB;
            end
            S_RWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch     = 1'b1;
                pcsource   = 2'b01;
                state_next = S_FETCH;
            end
            S_JMP: begin
                pcwrite    = 1'b1;
                pcsource   = 2'b10;
                state_next = S_FETCH;
            end
            S_AEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = S_AWB;
            end
            S_AWB: begin
                regwrite   = 1'b1;
                state_next = S_FETCH;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNE: begin
                alusrca    = 1'b1;
                aluop      = 2'b01;
                branch_ne  = 1'b1;
                pcsource   = 2'b01;
                state_next = S_FETCH;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: WIDTH=8 and WIDTH=32 instances checked against per-cycle expected strobes.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       memtoreg;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [3:0] irwrite;
        logic       pcwrite;
        logic       branch;
        logic       branch_ne;
        logic       illegal_op;
    } ov_t;

    typedef enum {X_FETCH, X_DEC, X_ILL, X_MEMADR, X_LBRD, X_LBWR, X_SBWR,
                  X_REX, X_RWB, X_BEQ, X_JMP, X_AEX, X_AWB, X_BNE} xs_t;

    typedef struct {
        ov_t        exp;
        logic       rdy;
        logic [5:0] opv;
        string      tag;
    } ent_t;

    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;

    logic       a_memread, a_memwrite, a_alusrca, a_memtoreg, a_iord, a_regwrite, a_regdst;
    logic       a_pcwrite, a_branch, a_branch_ne, a_illegal_op;
    logic [1:0] a_alusrcb, a_aluop, a_pcsource;
    logic [3:0] a_irwrite;
    logic       b_memread, b_memwrite, b_alusrca, b_memtoreg, b_iord, b_regwrite, b_regdst;
    logic       b_pcwrite, b_branch, b_branch_ne, b_illegal_op;
    logic [1:0] b_alusrcb, b_aluop, b_pcsource;
    logic [0:0] b_irwrite;

    ov_t obs8, obs32;
    assign obs8  = {a_memread, a_memwrite, a_alusrca, a_alusrcb, a_aluop, a_memtoreg, a_iord,
                    a_regwrite, a_regdst, a_pcsource, a_irwrite, a_pcwrite, a_branch,
                    a_branch_ne, a_illegal_op};
    assign obs32 = {b_memread, b_memwrite, b_alusrca, b_alusrcb, b_aluop, b_memtoreg, b_iord,
                    b_regwrite, b_regdst, b_pcsource, 3'b000, b_irwrite, b_pcwrite, b_branch,
                    b_branch_ne, b_illegal_op};

    mips_mc_controller #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .memread(a_memread), .memwrite(a_memwrite), .alusrca(a_alusrca), .alusrcb(a_alusrcb),
        .aluop(a_aluop), .memtoreg(a_memtoreg), .iord(a_iord), .regwrite(a_regwrite),
        .regdst(a_regdst), .pcsource(a_pcsource), .irwrite(a_irwrite), .pcwrite(a_pcwrite),
        .branch(a_branch), .branch_ne(a_branch_ne), .illegal_op(a_illegal_op)
    );

    mips_mc_controller #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .memread(b_memread), .memwrite(b_memwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
        .aluop(b_aluop), .memtoreg(b_memtoreg), .iord(b_iord), .regwrite(b_regwrite),
        .regdst(b_regdst), .pcsource(b_pcsource), .irwrite(b_irwrite), .pcwrite(b_pcwrite),
        .branch(b_branch), .branch_ne(b_branch_ne), .illegal_op(b_illegal_op)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic ov_t exp_of(input xs_t s, input int k, input logic rdy);
        ov_t v = '0;
        case (s)
            X_FETCH: begin
                v.memread = 1'b1;
                v.alusrcb = 2'b01;
                if (rdy) begin
                    v.irwrite[k] = 1'b1;
                    v.pcwrite    = 1'b1;
                end
            end
            X_DEC:    v.alusrcb = 2'b11;
            X_ILL:    begin v.alusrcb = 2'b11; v.illegal_op = 1'b1; end
            X_MEMADR: begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
            X_LBRD:   begin v.memread = 1'b1; v.iord = 1'b1; end
            X_LBWR:   begin v.regwrite = 1'b1; v.memtoreg = 1'b1; end
            X_SBWR:   begin v.memwrite = 1'b1; v.iord = 1'b1; end
            X_REX:    begin v.alusrca = 1'b1; v.aluop = 2'b10; end
            X_RWB:    begin v.regwrite = 1'b1; v.regdst = 1'b1; end
            X_BEQ:    begin v.alusrca = 1'b1; v.aluop = 2'b01; v.branch = 1'b1; v.pcsource = 2'b01; end
            X_JMP:    begin v.pcwrite = 1'b1; v.pcsource = 2'b10; end
            X_AEX:    begin v.alusrca = 1'b1; v.alusrcb = 2'b10; end
            X_AWB:    v.regwrite = 1'b1;
            X_BNE:    begin v.alusrca = 1'b1; v.aluop = 2'b01; v.branch_ne = 1'b1; v.pcsource = 2'b01; end
            default:  v = '0;
        endcase
        return v;
    endfunction

    task automatic push(input xs_t s, input int k, input logic rdy, input logic [5:0] opv);
        ent_t e;
        e.exp = exp_of(s, k, rdy);
        e.rdy = rdy;
        e.opv = opv;
        e.tag = s.name();
        sb_q.push_back(e);
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(63));
    endfunction

    // op is randomised in every cycle except DECODE/MEMADR, where it must be honoured.
    task automatic push_instr(input logic [5:0] opv, input int nbeat, input int fw_beat,
                              input int fw_n, input int mw_n);
        for (int k = 0; k < nbeat; k++) begin
            if (k == fw_beat)
                for (int w = 0; w < fw_n; w++) push(X_FETCH, k, 1'b0, rnd_op());
            push(X_FETCH, k, 1'b1, rnd_op());
        end
        case (opv)
            OP_LB: begin
                push(X_DEC, 0, 1'b1, opv);
                push(X_MEMADR, 0, 1'b1, opv);
                for (int w = 0; w < mw_n; w++) push(X_LBRD, 0, 1'b0, rnd_op());
                push(X_LBRD, 0, 1'b1, rnd_op());
                push(X_LBWR, 0, 1'b1, rnd_op());
            end
            OP_SB: begin
                push(X_DEC, 0, 1'b1, opv);
                push(X_MEMADR, 0, 1'b1, opv);
                for (int w = 0; w < mw_n; w++) push(X_SBWR, 0, 1'b0, rnd_op());
                push(X_SBWR, 0, 1'b1, rnd_op());
            end
            OP_R: begin
                push(X_DEC, 0, 1'b1, opv);
                push(X_REX, 0, 1'b1, rnd_op());
                push(X_RWB, 0, 1'b1, rnd_op());
            end
            OP_BEQ: begin
                push(X_DEC, 0, 1'b1, opv);
                push(X_BEQ, 0, 1'b1, rnd_op());
            end
            OP_J: begin
                push(X_DEC, 0, 1'b1, opv);
                push(X_JMP, 0, 1'b1, rnd_op());
            end
            OP_ADDI: begin
                push(X_DEC, 0, 1'b1, opv);
                push(X_AEX, 0, 1'b1, rnd_op());
                push(X_AWB, 0, 1'b1, rnd_op());
            end
`ifdef MIPS_CTRL_BNE_EN
            OP_BNE: begin
                push(X_DEC, 0, 1'b1, opv);
                push(X_BNE, 0, 1'b1, rnd_op());
            end
`endif
            default: push(X_ILL, 0, 1'b1, opv);
        endcase
    endtask

    task automatic drain(input bit sel32);
        ent_t e;
        ov_t  obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk);
            #1;
            mem_ready = e.rdy;
            op        = e.opv;
            #1;
            obs = sel32 ? obs32 : obs8;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s (w%0d): observed %h required %h", e.tag, sel32 ? 32 : 8, obs, e.exp);
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (obs8 !== '0 || obs32 !== '0) begin
            errors++;
            $display("FAIL reset_assert: observed %h/%h required 0", obs8, obs32);
        end
        @(posedge clk);
        mem_ready = 1'b1;
        #2;
        checks++;
        if (obs8 !== '0 || obs32 !== '0) begin
            errors++;
            $display("FAIL reset_hold: observed %h/%h required 0", obs8, obs32);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs8 !== '0 || obs32 !== '0) begin
            errors++;
            $display("FAIL reset_idle: observed %h/%h required 0", obs8, obs32);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_rtype();
        push_instr(OP_R, 4, 0, 0, 0);
        drain(1'b0);
    endtask

    task automatic test_fetch_wait();
        push_instr(OP_R, 4, 1, 3, 0);
        drain(1'b0);
    endtask

    task automatic test_back_to_back();
        push_instr(OP_LB, 4, 0, 0, 0);
        push_instr(OP_SB, 4, 0, 0, 0);
        push_instr(OP_BEQ, 4, 0, 0, 0);
        push_instr(OP_J, 4, 0, 0, 0);
        push_instr(OP_ADDI, 4, 0, 0, 0);
        push_instr(OP_R, 4, 0, 0, 0);
        drain(1'b0);
    endtask

    task automatic test_mem_wait();
        push_instr(OP_LB, 4, 3, 2, 2);
        push_instr(OP_SB, 4, 0, 1, 3);
        drain(1'b0);
    endtask

    task automatic test_illegal();
        push_instr(6'b111111, 4, 0, 0, 0);
        push_instr(6'b010101, 4, 0, 0, 0);
        push_instr(OP_R, 4, 0, 0, 0);
        drain(1'b0);
    endtask

    task automatic test_bne();
        push_instr(OP_BNE, 4, 0, 0, 0);
        push_instr(OP_BEQ, 4, 0, 0, 0);
        drain(1'b0);
    endtask

    task automatic test_reset_mid();
        ent_t dropped;
        push_instr(OP_SB, 4, 0, 0, 2);
        dropped = sb_q.pop_back();
        drain(1'b0);
        apply_reset();
        push_instr(OP_J, 4, 0, 0, 0);
        drain(1'b0);
    endtask

    task automatic test_width32();
        apply_reset();
        push_instr(OP_LB, 1, 0, 0, 0);
        push_instr(OP_BEQ, 1, 0, 0, 0);
        push_instr(OP_SB, 1, 0, 2, 1);
        push_instr(6'b111111, 1, 0, 0, 0);
        drain(1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        op        = 6'b0;
        mem_ready = 1'b0;
        #1;
        test_reset();
        test_rtype();
        test_fetch_wait();
        test_back_to_back();
        test_mem_wait();
        test_illegal();
        test_bne();
        test_reset_mid();
        test_width32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
